histogram_engine: RTL and testbench



---
 rtl/histogram_engine.sv | 214 +++++++++++++++++++++
 tb/tb_histogram_engine.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/histogram_engine.sv
// Per-frame pixel histogram: pipelined read-modify-write accumulation with hazard
// forwarding, then a clear-on-read valid/ready stream of every bin.
module histogram_engine #(
  parameter int unsigned PIXEL_W = 10,
  parameter int unsigned BIN_W   = 10,
  parameter int unsigned COUNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start_i,
  input  logic               frame_end_i,
  input  logic               pixel_valid_i,
  input  logic [PIXEL_W-1:0] pixel_i,
  output logic               pixel_ready_o,
  output logic               rd_valid_o,
  input  logic               rd_ready_i,
  output logic [BIN_W-1:0]   rd_bin_o,
  output logic [COUNT_W-1:0] rd_count_o,
  output logic               rd_last_o,
  output logic               overflow_o,
  output logic               busy_o
);

  localparam int unsigned NBINS = 1 << BIN_W;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_ACCUM,
    S_DRAIN,
    S_READOUT
  } state_t;

  state_t state, state_next;

  logic [BIN_W-1:0]   clr_idx;
  logic [COUNT_W-1:0] mem [NBINS];
  logic [COUNT_W-1:0] mem_rdata;

  logic [BIN_W-1:0]   raddr_c;
  logic [BIN_W-1:0]   waddr_c;
  logic [COUNT_W-1:0] wdata_c;
  logic               we_c;

  logic               accept_c;
  logic [BIN_W-1:0]   pix_bin_c;
  logic [COUNT_W-1:0] base_c;
  logic               sat_c;

  logic               s1_valid, s2_valid, s3_valid;
  logic [BIN_W-1:0]   s1_bin, s2_bin, s3_bin;
  logic [COUNT_W-1:0] s2_data, s3_data;

  logic [BIN_W:0]     nxt;
  logic               rf_valid;
  logic [BIN_W-1:0]   rf_bin;
  logic               xfer_c;
  logic               load_c;
  logic [BIN_W:0]     fetch_c;
  logic               issue_c;

  assign accept_c  = pixel_valid_i && pixel_ready_o;
  assign pix_bin_c = pixel_i[PIXEL_W-1 -: BIN_W];

  // Newest in-flight write wins: S2 is being written now, S3 landed last cycle
  // after this bin's read had already sampled the array.
  always_comb begin
    base_c = mem_rdata;
    if (s2_valid && (s2_bin == s1_bin)) begin
      base_c = s2_data;
    end else if (s3_valid && (s3_bin == s1_bin)) begin
      base_c = s3_data;
    end
    sat_c = &base_c;
  end

  // Readout prefetch: always read the bin that will be needed after this cycle.
  assign xfer_c  = rd_valid_o && rd_ready_i;
  assign load_c  = (state == S_READOUT) && rf_valid && ({1'b0, rf_bin} == nxt)
                   && (!rd_valid_o || xfer_c);
  assign fetch_c = load_c ? nxt + (BIN_W+1)'(1) : nxt;
  assign issue_c = (state == S_READOUT) && !fetch_c[BIN_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_CLEAR;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_CLEAR:   if (&clr_idx) state_next = S_IDLE;
      S_IDLE:    if (frame_start_i) state_next = S_ACCUM;
      S_ACCUM:   if (frame_end_i) state_next = S_DRAIN;
      // Once S1 is empty the final S2 write lands this cycle, ahead of the first readout read.
      S_DRAIN:   if (!s1_valid) state_next = S_READOUT;
      S_READOUT: if (xfer_c && rd_last_o) state_next = S_IDLE;
      default:   state_next = S_CLEAR;
    endcase
  end

  // Memory port steering per phase.
  always_comb begin
    raddr_c = pix_bin_c;
    waddr_c = s2_bin;
    wdata_c = s2_data;
    we_c    = 1'b0;
    case (state)
      S_CLEAR: begin
        we_c    = 1'b1;
        waddr_c = clr_idx;
        wdata_c = '0;
      end
      S_READOUT: begin
        raddr_c = fetch_c[BIN_W-1:0];
        we_c    = xfer_c;
        waddr_c = rd_bin_o;
        wdata_c = '0;
      end
      default: we_c = s2_valid;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we_c) begin
      mem[waddr_c] <= wdata_c;
    end
    mem_rdata <= mem[raddr_c];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_idx <= '0;
    end else if (state == S_CLEAR) begin
      clr_idx <= clr_idx + BIN_W'(1);
    end
  end

  // RMW pipeline: S0 issues read, S1 computes saturating increment, S2 writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      s1_bin   <= '0;
      s2_bin   <= '0;
      s3_bin   <= '0;
      s2_data  <= '0;
      s3_data  <= '0;
    end else begin
      s1_valid <= accept_c;
      s1_bin   <= pix_bin_c;
      s2_valid <= s1_valid;
      s2_bin   <= s1_bin;
      s2_data  <= sat_c ? base_c : base_c + COUNT_W'(1);
      s3_valid <= s2_valid;
      s3_bin   <= s2_bin;
      s3_data  <= s2_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_o <= 1'b0;
    end else if ((state == S_IDLE) && frame_start_i) begin
      overflow_o <= 1'b0;
    end else if (s1_valid && sat_c) begin
      overflow_o <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_ready_o <= 1'b0;
      busy_o        <= 1'b1;
    end else begin
      pixel_ready_o <= (state_next == S_ACCUM);
      busy_o        <= (state_next != S_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      nxt        <= '0;
      rf_valid   <= 1'b0;
      rf_bin     <= '0;
      rd_valid_o <= 1'b0;
      rd_bin_o   <= '0;
      rd_count_o <= '0;
      rd_last_o  <= 1'b0;
    end else begin
      rf_valid <= issue_c;
      rf_bin   <= fetch_c[BIN_W-1:0];
      if (state != S_READOUT) begin
        nxt <= '0;
      end else if (load_c) begin
        nxt <= nxt + (BIN_W+1)'(1);
      end
      if (load_c) begin
        rd_valid_o <= 1'b1;
        rd_bin_o   <= rf_bin;
        rd_count_o <= mem_rdata;
        rd_last_o  <= &rf_bin;
      end else if (xfer_c) begin
        rd_valid_o <= 1'b0;
        rd_last_o  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_histogram_engine.sv
// Directed bench for histogram_engine: default config, a 4-bit-count instance and a
// 256-bin instance, selected one at a time through a shared stimulus/observation mux.
module tb_histogram_engine;

  localparam int unsigned NB = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       fs, fe, pv, rr;
  logic [9:0] pix;
  int         sel;

  logic        d0_ready, d0_valid, d0_last, d0_ovf, d0_busy;
  logic [9:0]  d0_bin;
  logic [31:0] d0_count;
  logic        d1_ready, d1_valid, d1_last, d1_ovf, d1_busy;
  logic [9:0]  d1_bin;
  logic [3:0]  d1_count;
  logic        d2_ready, d2_valid, d2_last, d2_ovf, d2_busy;
  logic [7:0]  d2_bin;
  logic [31:0] d2_count;

  histogram_engine u0 (
    .clk(clk), .reset(reset), .frame_start_i(fs && (sel == 0)), .frame_end_i(fe && (sel == 0)),
    .pixel_valid_i(pv && (sel == 0)), .pixel_i(pix), .pixel_ready_o(d0_ready),
    .rd_valid_o(d0_valid), .rd_ready_i(rr && (sel == 0)), .rd_bin_o(d0_bin),
    .rd_count_o(d0_count), .rd_last_o(d0_last), .overflow_o(d0_ovf), .busy_o(d0_busy)
  );

  histogram_engine #(.COUNT_W(4)) u1 (
    .clk(clk), .reset(reset), .frame_start_i(fs && (sel == 1)), .frame_end_i(fe && (sel == 1)),
    .pixel_valid_i(pv && (sel == 1)), .pixel_i(pix), .pixel_ready_o(d1_ready),
    .rd_valid_o(d1_valid), .rd_ready_i(rr && (sel == 1)), .rd_bin_o(d1_bin),
    .rd_count_o(d1_count), .rd_last_o(d1_last), .overflow_o(d1_ovf), .busy_o(d1_busy)
  );

  histogram_engine #(.BIN_W(8)) u2 (
    .clk(clk), .reset(reset), .frame_start_i(fs && (sel == 2)), .frame_end_i(fe && (sel == 2)),
    .pixel_valid_i(pv && (sel == 2)), .pixel_i(pix), .pixel_ready_o(d2_ready),
    .rd_valid_o(d2_valid), .rd_ready_i(rr && (sel == 2)), .rd_bin_o(d2_bin),
    .rd_count_o(d2_count), .rd_last_o(d2_last), .overflow_o(d2_ovf), .busy_o(d2_busy)
  );

  logic        m_ready, m_valid, m_last, m_ovf, m_busy;
  logic [9:0]  m_bin;
  logic [31:0] m_count;

  always_comb begin
    m_ready = d0_ready; m_valid = d0_valid; m_last = d0_last; m_ovf = d0_ovf;
    m_busy  = d0_busy;  m_bin   = d0_bin;   m_count = d0_count;
    if (sel == 1) begin
      m_ready = d1_ready; m_valid = d1_valid; m_last = d1_last; m_ovf = d1_ovf;
      m_busy  = d1_busy;  m_bin   = d1_bin;   m_count = 32'(d1_count);
    end else if (sel == 2) begin
      m_ready = d2_ready; m_valid = d2_valid; m_last = d2_last; m_ovf = d2_ovf;
      m_busy  = d2_busy;  m_bin   = 10'(d2_bin); m_count = d2_count;
    end
  end

  int tests = 0;
  int fails = 0;

  int got [NB];
  int beats, lasts, last_bin, order_err, stall_err, nonzero;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    fs = 1'b1; step; fs = 1'b0;
  endtask

  task automatic pulse_end;
    fe = 1'b1; step; fe = 1'b0;
  endtask

  task automatic feed(input logic [9:0] p, input int n);
    pv = 1'b1; pix = p;
    repeat (n) step;
    pv = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (m_busy && n < 3000) begin
      step;
      n++;
    end
  endtask

  // Consumes a full readout, recording counts per bin plus ordering/stall statistics.
  task automatic readout(input int nb, input bit toggle);
    int          cyc;
    bit          prev_stall;
    logic [9:0]  pb;
    logic [31:0] pc;
    logic        pl;
    for (int i = 0; i < NB; i++) got[i] = 0;
    beats = 0; lasts = 0; last_bin = -1; order_err = 0; stall_err = 0; nonzero = 0;
    prev_stall = 1'b0; pb = '0; pc = '0; pl = 1'b0; cyc = 0;
    while (beats < nb && cyc < 6000) begin
      rr = toggle ? ((cyc % 2) == 1) : 1'b1;
      if (prev_stall && (!m_valid || m_bin !== pb || m_count !== pc || m_last !== pl))
        stall_err++;
      if (m_valid && rr) begin
        if (m_bin !== 10'(beats)) order_err++;
        got[m_bin] = int'(m_count);
        if (m_last) begin
          lasts++;
          last_bin = int'(m_bin);
        end
        beats++;
      end
      prev_stall = m_valid && !rr;
      pb = m_bin; pc = m_count; pl = m_last;
      step;
      cyc++;
    end
    rr = 1'b0;
    for (int i = 0; i < NB; i++) if (got[i] != 0) nonzero++;
  endtask

  task automatic test_reset;
    int n;
    sel = 0;
    reset = 1'b1;
    repeat (3) step;
    tests++; if (m_busy !== 1'b1) begin fails++; $display("FAIL reset_busy got %0b exp 1", m_busy); end
    tests++; if (m_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %0b exp 0", m_ready); end
    tests++; if (m_valid !== 1'b0 || m_last !== 1'b0) begin fails++; $display("FAIL reset_valid_last got %0b%0b exp 00", m_valid, m_last); end
    tests++; if (m_bin !== 10'd0 || m_count !== 32'd0) begin fails++; $display("FAIL reset_bin_count got %0d/%0d exp 0/0", m_bin, m_count); end
    tests++; if (m_ovf !== 1'b0) begin fails++; $display("FAIL reset_overflow got %0b exp 0", m_ovf); end
    reset = 1'b0;
    wait_idle(n);
    tests++; if (n != 1024) begin fails++; $display("FAIL clear_cycles got %0d exp 1024", n); end
  endtask

  task automatic test_empty_frame;
    pulse_start;
    tests++; if (m_ready !== 1'b1) begin fails++; $display("FAIL accum_ready got %0b exp 1", m_ready); end
    pulse_end;
    tests++; if (m_ready !== 1'b0) begin fails++; $display("FAIL drain_ready got %0b exp 0", m_ready); end
    readout(1024, 1'b0);
    tests++; if (beats != 1024) begin fails++; $display("FAIL empty_beats got %0d exp 1024", beats); end
    tests++; if (nonzero != 0) begin fails++; $display("FAIL empty_nonzero_bins got %0d exp 0", nonzero); end
    tests++; if (lasts != 1 || last_bin != 1023) begin fails++; $display("FAIL empty_last got %0d@%0d exp 1@1023", lasts, last_bin); end
    tests++; if (order_err != 0) begin fails++; $display("FAIL empty_order got %0d exp 0", order_err); end
    tests++; if (m_valid !== 1'b0 || m_busy !== 1'b0) begin fails++; $display("FAIL empty_idle got v%0b b%0b exp v0 b0", m_valid, m_busy); end
  endtask

  task automatic test_forwarding;
    pulse_start;
    feed(10'h155, 5);
    pulse_end;
    readout(1024, 1'b0);
    tests++; if (got[341] != 5) begin fails++; $display("FAIL fwd_bin341 got %0d exp 5", got[341]); end
    tests++; if (nonzero != 1) begin fails++; $display("FAIL fwd_nonzero_bins got %0d exp 1", nonzero); end
    tests++; if (beats != 1024) begin fails++; $display("FAIL fwd_beats got %0d exp 1024", beats); end
  endtask

  task automatic test_back_to_back;
    pulse_start;
    pv = 1'b1;
    for (int i = 0; i < 16; i++) begin
      pix = (i % 2 == 0) ? 10'd3 : 10'd4;
      step;
    end
    pix = 10'd9; fe = 1'b1;
    step;
    pv = 1'b0; fe = 1'b0;
    readout(1024, 1'b1);
    tests++; if (got[3] != 8) begin fails++; $display("FAIL alt_bin3 got %0d exp 8", got[3]); end
    tests++; if (got[4] != 8) begin fails++; $display("FAIL alt_bin4 got %0d exp 8", got[4]); end
    tests++; if (got[9] != 1) begin fails++; $display("FAIL alt_bin9 got %0d exp 1", got[9]); end
    tests++; if (nonzero != 3) begin fails++; $display("FAIL alt_nonzero_bins got %0d exp 3", nonzero); end
    tests++; if (beats != 1024 || order_err != 0) begin fails++; $display("FAIL stall_order got %0d beats %0d errs exp 1024/0", beats, order_err); end
    tests++; if (stall_err != 0) begin fails++; $display("FAIL stall_stable got %0d exp 0", stall_err); end
    tests++; if (lasts != 1) begin fails++; $display("FAIL stall_lasts got %0d exp 1", lasts); end
  endtask

  task automatic test_saturation;
    int n;
    sel = 1;
    reset = 1'b1; repeat (2) step; reset = 1'b0;
    wait_idle(n);
    pulse_start;
    feed(10'd7, 20);
    pulse_end;
    readout(1024, 1'b0);
    tests++; if (got[7] != 15) begin fails++; $display("FAIL sat_bin7 got %0d exp 15", got[7]); end
    tests++; if (nonzero != 1) begin fails++; $display("FAIL sat_nonzero_bins got %0d exp 1", nonzero); end
    tests++; if (m_ovf !== 1'b1) begin fails++; $display("FAIL sat_overflow got %0b exp 1", m_ovf); end
    pulse_start;
    tests++; if (m_ovf !== 1'b0) begin fails++; $display("FAIL sat_overflow_clear got %0b exp 0", m_ovf); end
    feed(10'd7, 2);
    pulse_end;
    readout(1024, 1'b0);
    tests++; if (got[7] != 2) begin fails++; $display("FAIL sat_clear_on_read got %0d exp 2", got[7]); end
    tests++; if (m_ovf !== 1'b0) begin fails++; $display("FAIL sat_overflow_hold got %0b exp 0", m_ovf); end
  endtask

  task automatic test_bin_w8;
    int n;
    sel = 2;
    reset = 1'b1; repeat (2) step; reset = 1'b0;
    wait_idle(n);
    tests++; if (n != 256) begin fails++; $display("FAIL b8_clear_cycles got %0d exp 256", n); end
    pulse_start;
    feed(10'h3FF, 1);
    pulse_end;
    readout(256, 1'b0);
    tests++; if (got[255] != 1 || nonzero != 1) begin fails++; $display("FAIL b8_bin255 got %0d (%0d bins) exp 1 (1 bins)", got[255], nonzero); end
    tests++; if (beats != 256 || last_bin != 255) begin fails++; $display("FAIL b8_beats got %0d last %0d exp 256 last 255", beats, last_bin); end
    pulse_start;
    feed(10'h3FF, 4);
    feed(10'h0C4, 6);
    reset = 1'b1;
    step;
    tests++; if (m_ready !== 1'b0 || m_busy !== 1'b1) begin fails++; $display("FAIL b8_mid_reset got r%0b b%0b exp r0 b1", m_ready, m_busy); end
    step;
    reset = 1'b0;
    wait_idle(n);
    tests++; if (n != 256) begin fails++; $display("FAIL b8_reclear_cycles got %0d exp 256", n); end
    pulse_start;
    feed(10'h000, 1);
    pulse_end;
    readout(256, 1'b0);
    tests++; if (got[0] != 1) begin fails++; $display("FAIL b8_bin0 got %0d exp 1", got[0]); end
    tests++; if (nonzero != 1) begin fails++; $display("FAIL b8_nonzero_bins got %0d exp 1", nonzero); end
  endtask

  initial begin
    reset = 1'b1; fs = 1'b0; fe = 1'b0; pv = 1'b0; rr = 1'b0; pix = '0; sel = 0;
    test_reset;
    test_empty_frame;
    test_forwarding;
    test_back_to_back;
    test_saturation;
    test_bin_w8;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
